// File: rtl/sw_seq_player.sv
// Sequence player: replays a programmed list of switch symbols as one-hot
// pulses with programmable hold width and inter-symbol gap.
module sw_seq_player #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned HOLD_W = 4,
    parameter int unsigned NUM_SW = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [2:0]                 wr_sym,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic [HOLD_W-1:0]          hold,
    input  logic [HOLD_W-1:0]          gap,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic [NUM_SW-1:0]          sw_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic [SW-1:0]       mem [DEPTH];
    logic [LW-1:0]       len_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   gap_q;
    logic [HOLD_W-1:0]   cnt;

    logic                len_ok;
    logic                last_slot;
    logic [AW-1:0]       nxt_idx;
    logic [NUM_SW-1:0]   first_sw;
    logic [NUM_SW-1:0]   nxt_sw;
    logic                first_ill;
    logic                nxt_ill;

    // Symbol to one-hot drive; out-of-range symbols drive nothing.
    function automatic logic [NUM_SW-1:0] decode(input logic [SW-1:0] s);
        if (32'(s) < NUM_SW) begin
            return NUM_SW'(1) << s;
        end
        return '0;
    endfunction

    always_comb begin
        len_ok    = (len != '0) && (32'(len) <= DEPTH);
        last_slot = (LW'(idx) == (len_q - LW'(1)));
        nxt_idx   = idx + AW'(1);
        first_sw  = decode(mem[0]);
        first_ill = (32'(mem[0]) >= NUM_SW);
        nxt_sw    = decode(mem[nxt_idx]);
        nxt_ill   = (32'(mem[nxt_idx]) >= NUM_SW);
    end

    // Sequence memory; frozen while a playback is running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !busy) begin
            mem[wr_addr] <= wr_sym;
        end
    end

    // Playback FSM; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            idx    <= '0;
            sw_out <= '0;
            len_q  <= '0;
            hold_q <= '0;
            gap_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q  <= len;
                            hold_q <= hold;
                            gap_q  <= gap;
                            cnt    <= hold;
                            idx    <= '0;
                            err    <= first_ill;
                            sw_out <= first_sw;
                            busy   <= 1'b1;
                            state  <= S_DRIVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DRIVE, S_GAP: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        sw_out <= '0;
                        cnt    <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - HOLD_W'(1);
                    end else if ((state == S_DRIVE) && (gap_q != '0)) begin
                        cnt    <= gap_q - HOLD_W'(1);
                        sw_out <= '0;
                        state  <= S_GAP;
                    end else if (last_slot) begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        sw_out <= '0;
                        state  <= S_DONE;
                    end else begin
                        // Direct hand-off keeps a repeated symbol high with no dip.
                        idx    <= nxt_idx;
                        cnt    <= hold_q;
                        sw_out <= nxt_sw;
                        err    <= err | nxt_ill;
                        state  <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
